// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster scan source (640x480@60 by default).
// Produces the DrawX/DrawY scan coordinates for the pixel pipeline and a per-pixel
// clock enable. It also drives frame_clk for per-frame game logic. Sync and blank
// are delayed through a PIPE_DLY-deep shift register so they line up with the
// pipeline's Red/Green/Blue. The DAC colour is forced to black during blanking.
// Reset_n asserts asynchronously. Its release must already be synchronous to Clk.

module vga_scan_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 2,
    parameter int PIPE_DLY = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_clk,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [1:0] DIV_LAST   = 2'(PIX_DIV - 1);

    logic [1:0]          div_q, div_d;
    logic                pixel_ce_q, pixel_ce_d;
    logic [9:0]          draw_x_q, draw_x_d;
    logic [9:0]          draw_y_q, draw_y_d;
    logic                frame_clk_q, frame_clk_d;
    logic [PIPE_DLY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DLY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DLY-1:0] blank_pipe_q, blank_pipe_d;
    logic [23:0]         rgb_q, rgb_d;
    logic                hs_raw, vs_raw, blank_n_raw;

    // Pixel divider: pixel_ce is high for the one Clk where the divider sits at its last count
    always_comb begin
        div_d      = (div_q == DIV_LAST) ? 2'd0 : div_q + 2'd1;
        pixel_ce_d = (div_d == DIV_LAST);
    end

    // Scan counters advance once per pixel, wrapping X into Y and Y back to the top
    always_comb begin
        draw_x_d = draw_x_q;
        draw_y_d = draw_y_q;
        if (pixel_ce_q) begin
            if (draw_x_q == H_LAST) begin
                draw_x_d = 10'd0;
                draw_y_d = (draw_y_q == V_LAST) ? 10'd0 : draw_y_q + 10'd1;
            end else begin
                draw_x_d = draw_x_q + 10'd1;
            end
        end
    end

    // Undelayed timing decoded from the counters; frame_clk tracks the next counter state
    always_comb begin
        hs_raw      = !((draw_x_q >= HS_START) && (draw_x_q < HS_END));
        vs_raw      = !((draw_y_q >= VS_START) && (draw_y_q < VS_END));
        blank_n_raw = (draw_x_q < H_VIS_END) && (draw_y_q < V_VIS_END);
        frame_clk_d = !((draw_y_d >= VS_START) && (draw_y_d < VS_END));
    end

    // Delay line for sync/blank plus the colour register, both stepping once per pixel
    always_comb begin
        hs_pipe_d    = hs_pipe_q;
        vs_pipe_d    = vs_pipe_q;
        blank_pipe_d = blank_pipe_q;
        rgb_d        = rgb_q;
        if (pixel_ce_q) begin
            hs_pipe_d[0]    = hs_raw;
            vs_pipe_d[0]    = vs_raw;
            blank_pipe_d[0] = blank_n_raw;
            for (int i = 1; i < PIPE_DLY; i++) begin
                hs_pipe_d[i]    = hs_pipe_q[i-1];
                vs_pipe_d[i]    = vs_pipe_q[i-1];
                blank_pipe_d[i] = blank_pipe_q[i-1];
            end
            rgb_d = blank_pipe_d[PIPE_DLY-1] ? {Red_in, Green_in, Blue_in} : 24'd0;
        end
    end

    // State registers; reset parks the scan at (0,0) with syncs idle and the DAC black
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q        <= 2'd0;
            pixel_ce_q   <= 1'b0;
            draw_x_q     <= 10'd0;
            draw_y_q     <= 10'd0;
            frame_clk_q  <= 1'b1;
            hs_pipe_q    <= '1;
            vs_pipe_q    <= '1;
            blank_pipe_q <= '0;
            rgb_q        <= 24'd0;
        end else begin
            div_q        <= div_d;
            pixel_ce_q   <= pixel_ce_d;
            draw_x_q     <= draw_x_d;
            draw_y_q     <= draw_y_d;
            frame_clk_q  <= frame_clk_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
            blank_pipe_q <= blank_pipe_d;
            rgb_q        <= rgb_d;
        end
    end

    assign pixel_ce    = pixel_ce_q;
    assign DrawX       = draw_x_q;
    assign DrawY       = draw_y_q;
    assign frame_clk   = frame_clk_q;
    assign VGA_HS      = hs_pipe_q[PIPE_DLY-1];
    assign VGA_VS      = vs_pipe_q[PIPE_DLY-1];
    assign VGA_BLANK_N = blank_pipe_q[PIPE_DLY-1];
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed bench for vga_scan_gen.
// dut_a keeps the full 800-pixel line with PIX_DIV=2, PIPE_DLY=2 and a shortened
// 10-line frame. dut_b is a tiny 16x8 raster with PIX_DIV=1, PIPE_DLY=2.
// Each bench-side upstream model feeds back Red=DrawX, Green=DrawX^A5, Blue=DrawY
// through one pixel register, so the colour arrives PIPE_DLY pixel periods after DrawX.

module tb_vga_scan_gen;

    localparam int A_HVIS = 640, A_HFP = 16, A_HSYNC = 96, A_HBP = 48, A_HTOT = 800;
    localparam int A_VVIS = 4,   A_VFP = 2,  A_VSYNC = 2,  A_VBP = 2,  A_VTOT = 10;
    localparam int B_HVIS = 8,   B_HFP = 2,  B_HSYNC = 3,  B_HBP = 3,  B_HTOT = 16;
    localparam int B_VVIS = 4,   B_VFP = 1,  B_VSYNC = 2,  B_VBP = 1,  B_VTOT = 8;

    // {DrawX, DrawY, pixel_ce, frame_clk, HS, VS, BLANK_N, R, G, B, SYNC_N}
    localparam logic [49:0] RESET_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0};

    logic       clk;
    logic       rst_a_n, rst_b_n;
    logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic       pce_a, fclk_a, hs_a, vs_a, bl_a, sync_a;
    logic       pce_b, fclk_b, hs_b, vs_b, bl_b, sync_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic [49:0] obs_a, obs_b;
    logic       cap_ce_a, cap_ce_b;
    logic [9:0] cap_x_a, cap_y_a, cap_x_b, cap_y_b;

    int checks;
    int passed;
    int ea;
    int eb;

    assign obs_a = {x_a, y_a, pce_a, fclk_a, hs_a, vs_a, bl_a, r_a, g_a, b_a, sync_a};
    assign obs_b = {x_b, y_b, pce_b, fclk_b, hs_b, vs_b, bl_b, r_b, g_b, b_b, sync_b};

    vga_scan_gen #(
        .H_VIS(A_HVIS), .H_FP(A_HFP), .H_SYNC(A_HSYNC), .H_BP(A_HBP),
        .V_VIS(A_VVIS), .V_FP(A_VFP), .V_SYNC(A_VSYNC), .V_BP(A_VBP),
        .PIX_DIV(2), .PIPE_DLY(2)
    ) dut_a (
        .Clk(clk), .Reset_n(rst_a_n),
        .Red_in(red_a), .Green_in(green_a), .Blue_in(blue_a),
        .pixel_ce(pce_a), .DrawX(x_a), .DrawY(y_a), .frame_clk(fclk_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a), .VGA_SYNC_N(sync_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
    );

    vga_scan_gen #(
        .H_VIS(B_HVIS), .H_FP(B_HFP), .H_SYNC(B_HSYNC), .H_BP(B_HBP),
        .V_VIS(B_VVIS), .V_FP(B_VFP), .V_SYNC(B_VSYNC), .V_BP(B_VBP),
        .PIX_DIV(1), .PIPE_DLY(2)
    ) dut_b (
        .Clk(clk), .Reset_n(rst_b_n),
        .Red_in(red_b), .Green_in(green_b), .Blue_in(blue_b),
        .pixel_ce(pce_b), .DrawX(x_b), .DrawY(y_b), .frame_clk(fclk_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sync_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream pixel pipeline model for dut_a: one register stage clocked by pixel_ce
    initial begin
        red_a = 8'd0; green_a = 8'd0; blue_a = 8'd0;
        forever begin
            @(negedge clk);
            cap_ce_a = pce_a; cap_x_a = x_a; cap_y_a = y_a;
            @(posedge clk);
            #1;
            if (cap_ce_a) begin
                red_a = cap_x_a[7:0]; green_a = cap_x_a[7:0] ^ 8'hA5; blue_a = cap_y_a[7:0];
            end
        end
    end

    // Upstream pixel pipeline model for dut_b
    initial begin
        red_b = 8'd0; green_b = 8'd0; blue_b = 8'd0;
        forever begin
            @(negedge clk);
            cap_ce_b = pce_b; cap_x_b = x_b; cap_y_b = y_b;
            @(posedge clk);
            #1;
            if (cap_ce_b) begin
                red_b = cap_x_b[7:0]; green_b = cap_x_b[7:0] ^ 8'hA5; blue_b = cap_y_b[7:0];
            end
        end
    end

    // Expected output vector e Clk edges after reset release, from the timing definition
    function automatic logic [49:0] exp_vec(input int e, input bit use_b);
        int div, htot, hvis, hss, hse, vtot, vvis, vss, vse, dly;
        int n, p, x, y, ax, ay;
        logic pce, fclk, hs, vs, bl;
        logic [7:0] r, g, b;
        dly = 2;
        if (use_b) begin
            div = 1; htot = B_HTOT; hvis = B_HVIS; hss = B_HVIS + B_HFP; hse = hss + B_HSYNC;
            vtot = B_VTOT; vvis = B_VVIS; vss = B_VVIS + B_VFP; vse = vss + B_VSYNC;
        end else begin
            div = 2; htot = A_HTOT; hvis = A_HVIS; hss = A_HVIS + A_HFP; hse = hss + A_HSYNC;
            vtot = A_VTOT; vvis = A_VVIS; vss = A_VVIS + A_VFP; vse = vss + A_VSYNC;
        end
        if (div == 1) begin
            n = (e >= 1) ? e - 1 : 0;
            pce = (e >= 1);
        end else begin
            n = e / div;
            pce = ((e % div) == (div - 1));
        end
        x = n % htot;
        y = (n / htot) % vtot;
        fclk = !(y >= vss && y < vse);
        if (n < dly) begin
            hs = 1'b1; vs = 1'b1; bl = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0;
        end else begin
            p  = n - dly;
            ax = p % htot;
            ay = (p / htot) % vtot;
            hs = !(ax >= hss && ax < hse);
            vs = !(ay >= vss && ay < vse);
            bl = (ax < hvis) && (ay < vvis);
            r  = bl ? 8'(ax) : 8'd0;
            g  = bl ? (8'(ax) ^ 8'hA5) : 8'd0;
            b  = bl ? 8'(ay) : 8'd0;
        end
        return {10'(x), 10'(y), pce, fclk, hs, vs, bl, r, g, b, 1'b0};
    endfunction

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (x_a !== 10'd0) $display("[TB] FAIL reset_drawx: got %0d want 0", x_a); else passed++;
        checks++; if (y_a !== 10'd0) $display("[TB] FAIL reset_drawy: got %0d want 0", y_a); else passed++;
        checks++; if (hs_a !== 1'b1) $display("[TB] FAIL reset_hs: got %b want 1", hs_a); else passed++;
        checks++; if (vs_a !== 1'b1) $display("[TB] FAIL reset_vs: got %b want 1", vs_a); else passed++;
        checks++; if (bl_a !== 1'b0) $display("[TB] FAIL reset_blank_n: got %b want 0", bl_a); else passed++;
        checks++; if ({r_a, g_a, b_a} !== 24'd0) $display("[TB] FAIL reset_rgb: got %h want 000000", {r_a, g_a, b_a}); else passed++;
        checks++; if (fclk_a !== 1'b1) $display("[TB] FAIL reset_frame_clk: got %b want 1", fclk_a); else passed++;
        checks++; if (pce_a !== 1'b0) $display("[TB] FAIL reset_pixel_ce: got %b want 0", pce_a); else passed++;
        checks++; if (sync_a !== 1'b0) $display("[TB] FAIL sync_n_tied: got %b want 0", sync_a); else passed++;
        checks++; if (obs_b !== RESET_VEC) $display("[TB] FAIL reset_div1: got %h want %h", obs_b, RESET_VEC); else passed++;
    endtask

    task automatic test_line_timing();
        int err, first_e, fall1, fall2, rise1;
        logic [49:0] want, first_got, first_want;
        logic prev_hs;
        err = 0; first_e = -1; fall1 = -1; fall2 = -1; rise1 = -1;
        first_got = '0; first_want = '0;
        rst_a_n = 1'b1;
        ea = 0;
        prev_hs = hs_a;
        for (int i = 0; i < 3400; i++) begin
            @(posedge clk);
            @(negedge clk);
            ea++;
            want = exp_vec(ea, 1'b0);
            if (obs_a !== want) begin
                if (err == 0) begin first_e = ea; first_got = obs_a; first_want = want; end
                err++;
            end
            if (prev_hs === 1'b1 && hs_a === 1'b0) begin
                if (fall1 < 0) fall1 = ea; else if (fall2 < 0) fall2 = ea;
            end
            if (prev_hs === 1'b0 && hs_a === 1'b1 && rise1 < 0) rise1 = ea;
            prev_hs = hs_a;
        end
        checks++; if (err !== 0) $display("[TB] FAIL line_model: %0d bad samples want 0, first edge %0d got %h want %h", err, first_e, first_got, first_want); else passed++;
        checks++; if (fall1 !== 1316) $display("[TB] FAIL hs_first_fall: got edge %0d want 1316", fall1); else passed++;
        checks++; if (rise1 - fall1 !== 192) $display("[TB] FAIL hs_width: got %0d clk want 192", rise1 - fall1); else passed++;
        checks++; if (fall2 - fall1 !== 1600) $display("[TB] FAIL line_period: got %0d clk want 1600", fall2 - fall1); else passed++;
    endtask

    task automatic test_frame_timing();
        int err, first_e, vs_falls, vs_fall1, vs_fall2, vs_rise1, fc_rises, fc_rise1;
        logic [49:0] want, first_got, first_want;
        logic [19:0] fc_pos, wrap_before, wrap_after;
        logic prev_vs, prev_fc;
        err = 0; first_e = -1; vs_falls = 0; vs_fall1 = -1; vs_fall2 = -1; vs_rise1 = -1;
        fc_rises = 0; fc_rise1 = -1;
        first_got = '0; first_want = '0; fc_pos = '1; wrap_before = '1; wrap_after = '1;
        prev_vs = vs_a;
        prev_fc = fclk_a;
        while (ea < 34000) begin
            @(posedge clk);
            @(negedge clk);
            ea++;
            want = exp_vec(ea, 1'b0);
            if (obs_a !== want) begin
                if (err == 0) begin first_e = ea; first_got = obs_a; first_want = want; end
                err++;
            end
            if (prev_vs === 1'b1 && vs_a === 1'b0) begin
                vs_falls++;
                if (vs_fall1 < 0) vs_fall1 = ea; else if (vs_fall2 < 0) vs_fall2 = ea;
            end
            if (prev_vs === 1'b0 && vs_a === 1'b1 && vs_fall1 >= 0 && vs_rise1 < 0) vs_rise1 = ea;
            if (prev_fc === 1'b0 && fclk_a === 1'b1) begin
                fc_rises++;
                if (fc_rise1 < 0) begin fc_rise1 = ea; fc_pos = {x_a, y_a}; end
            end
            if (ea == 15998) wrap_before = {x_a, y_a};
            if (ea == 16000) wrap_after = {x_a, y_a};
            prev_vs = vs_a;
            prev_fc = fclk_a;
        end
        checks++; if (err !== 0) $display("[TB] FAIL frame_model: %0d bad samples want 0, first edge %0d got %h want %h", err, first_e, first_got, first_want); else passed++;
        checks++; if (vs_falls !== 2) $display("[TB] FAIL vs_pulse_count: got %0d want 2", vs_falls); else passed++;
        checks++; if (vs_fall1 !== 9604) $display("[TB] FAIL vs_first_fall: got edge %0d want 9604", vs_fall1); else passed++;
        checks++; if (vs_rise1 - vs_fall1 !== 3200) $display("[TB] FAIL vs_width: got %0d clk want 3200", vs_rise1 - vs_fall1); else passed++;
        checks++; if (vs_fall2 - vs_fall1 !== 16000) $display("[TB] FAIL frame_period: got %0d clk want 16000", vs_fall2 - vs_fall1); else passed++;
        checks++; if (fc_rises !== 2) $display("[TB] FAIL frame_clk_rises: got %0d want 2", fc_rises); else passed++;
        checks++; if (fc_rise1 !== 12800) $display("[TB] FAIL frame_clk_rise_edge: got %0d want 12800", fc_rise1); else passed++;
        checks++; if (fc_pos !== {10'd0, 10'd8}) $display("[TB] FAIL frame_clk_rise_xy: got x=%0d y=%0d want x=0 y=8", fc_pos[19:10], fc_pos[9:0]); else passed++;
        checks++; if (wrap_before !== {10'd799, 10'd9}) $display("[TB] FAIL wrap_last: got x=%0d y=%0d want x=799 y=9", wrap_before[19:10], wrap_before[9:0]); else passed++;
        checks++; if (wrap_after !== {10'd0, 10'd0}) $display("[TB] FAIL wrap_first: got x=%0d y=%0d want x=0 y=0", wrap_after[19:10], wrap_after[9:0]); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int err, first_e, fall1;
        logic [49:0] want, first_got, first_want;
        logic prev_hs;
        err = 0; first_e = -1; fall1 = -1;
        first_got = '0; first_want = '0;
        while (ea < 43000) begin
            @(posedge clk);
            @(negedge clk);
            ea++;
            want = exp_vec(ea, 1'b0);
            if (obs_a !== want) begin
                if (err == 0) begin first_e = ea; first_got = obs_a; first_want = want; end
                err++;
            end
        end
        checks++; if (err !== 0) $display("[TB] FAIL pre_reset_model: %0d bad samples want 0, first edge %0d got %h want %h", err, first_e, first_got, first_want); else passed++;
        checks++; if ({hs_a, vs_a, fclk_a} !== 3'b000) $display("[TB] FAIL pre_reset_sync: got hs/vs/fclk=%b want 000", {hs_a, vs_a, fclk_a}); else passed++;
        #2;
        rst_a_n = 1'b0;
        #1;
        checks++; if (obs_a !== RESET_VEC) $display("[TB] FAIL async_reset: got %h want %h", obs_a, RESET_VEC); else passed++;
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1;
        ea = 0;
        err = 0; first_e = -1;
        prev_hs = hs_a;
        for (int i = 0; i < 1400; i++) begin
            @(posedge clk);
            @(negedge clk);
            ea++;
            want = exp_vec(ea, 1'b0);
            if (obs_a !== want) begin
                if (err == 0) begin first_e = ea; first_got = obs_a; first_want = want; end
                err++;
            end
            if (prev_hs === 1'b1 && hs_a === 1'b0 && fall1 < 0) fall1 = ea;
            prev_hs = hs_a;
        end
        checks++; if (err !== 0) $display("[TB] FAIL restart_model: %0d bad samples want 0, first edge %0d got %h want %h", err, first_e, first_got, first_want); else passed++;
        checks++; if (fall1 !== 1316) $display("[TB] FAIL restart_hs_fall: got edge %0d want 1316", fall1); else passed++;
    endtask

    task automatic test_alignment_div1();
        int err, first_e, fall1;
        logic [49:0] want, first_got, first_want;
        logic prev_hs;
        err = 0; first_e = -1; fall1 = -1;
        first_got = '0; first_want = '0;
        rst_b_n = 1'b1;
        eb = 0;
        prev_hs = hs_b;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            @(negedge clk);
            eb++;
            want = exp_vec(eb, 1'b1);
            if (obs_b !== want) begin
                if (err == 0) begin first_e = eb; first_got = obs_b; first_want = want; end
                err++;
            end
            if (prev_hs === 1'b1 && hs_b === 1'b0 && fall1 < 0) fall1 = eb;
            prev_hs = hs_b;
        end
        checks++; if (err !== 0) $display("[TB] FAIL div1_model: %0d bad samples want 0, first edge %0d got %h want %h", err, first_e, first_got, first_want); else passed++;
        checks++; if (fall1 !== 13) $display("[TB] FAIL div1_hs_fall: got edge %0d want 13", fall1); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        ea = 0;
        eb = 0;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_reset_mid_frame();
        test_alignment_div1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
